// File: rtl/uart_hex_pkg.sv
// Shared ASCII constants, parser state enum and hex-digit decoder for the UART hex-dword link.
// The tx printer reuses the same character constants.
package uart_hex_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_a  = 8'h61;
    localparam logic [7:0] CH_f  = 8'h66;
    localparam logic [7:0] CH_x  = 8'h78;
    localparam logic [7:0] CH_X  = 8'h58;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {IDLE, GOT0, DIGS, SKIP} state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] nib;
    } hex_t;

    function automatic hex_t ascii2nib(input logic [7:0] c);
        hex_t r;
        r.vld = 1'b1;
        r.nib = 4'd0;
        if (c >= CH_0 && c <= CH_9)      r.nib = 4'(c - CH_0);
        else if (c >= CH_A && c <= CH_F) r.nib = 4'(c - CH_A + 8'd10);
        else if (c >= CH_a && c <= CH_f) r.nib = 4'(c - CH_a + 8'd10);
        else                             r.vld = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_dword_hex_if.sv
// Result bus of the hex-dword receiver: parsed word with valid/error strobes and a busy flag.
interface uart_rx_dword_hex_if;
    logic [31:0] data;
    logic        valid;
    logic        err;
    logic        busy;

    modport master (output data, valid, err, busy);
    modport slave  (input  data, valid, err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver, 4x oversampled (one bit = 4*U_DIV clocks); 1-cycle o_stb with o_byte.
// No backpressure: a byte is presented once; framing errors (low stop bit) drop the byte.
module uart_rx #(
    parameter int U_DIV = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_rx,
    output logic       o_stb,
    output logic [7:0] o_byte
);
    localparam int FULL = 4 * U_DIV;
    localparam int HALF = 2 * U_DIV;
    localparam int CW   = $clog2(FULL + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

    rstate_t       state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= R_IDLE;
            sync    <= 2'b11;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            o_stb   <= 1'b0;
            o_byte  <= '0;
        end else begin
            sync  <= {sync[0], i_rx};
            o_stb <= 1'b0;
            case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (i_en && !sync[1]) state <= R_START;
                end
                // Re-check the start bit half a bit in, which also aligns later samples to mid-bit.
                R_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync[1] ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (cnt == CW'(FULL - 1)) begin
                        cnt     <= '0;
                        shift   <= {sync[1], shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= R_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt == CW'(FULL - 1)) begin
                        cnt   <= '0;
                        state <= R_IDLE;
                        if (sync[1]) begin
                            o_stb  <= 1'b1;
                            o_byte <= shift;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_dword_hex.sv
// Parses "0x" + 1..8 hex digits + CR/LF from the UART RX pin into a 32-bit word.
// Strobes valid/err one cycle after the deciding byte; no backpressure, one byte per rx strobe.
module uart_rx_dword_hex
    import uart_hex_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int U_DIV  = CLK_HZ / (4 * BAUD)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_uart_rx,
    uart_rx_dword_hex_if.master   bus
);
    logic        rx_stb;
    logic [7:0]  rx_byte;
    state_t      state;
    logic [31:0] acc;
    logic [3:0]  cnt;
    logic [31:0] data_q;
    logic        valid_q;
    logic        err_q;
    hex_t        h;
    logic        is_term;

    uart_rx #(.U_DIV(U_DIV)) u_rx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (1'b1),
        .i_rx   (i_uart_rx),
        .o_stb  (rx_stb),
        .o_byte (rx_byte)
    );

    assign h       = ascii2nib(rx_byte);
    assign is_term = (rx_byte == CH_CR) || (rx_byte == CH_LF);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (rx_stb) begin
                case (state)
                    // Stray bytes, including the LF of a CR/LF pair, are absorbed here.
                    IDLE: if (rx_byte == CH_0) state <= GOT0;
                    GOT0: begin
                        if (rx_byte == CH_x || rx_byte == CH_X) begin
                            state <= DIGS;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            err_q <= 1'b1;
                            state <= is_term ? IDLE : SKIP;
                        end
                    end
                    DIGS: begin
                        if (h.vld) begin
                            if (cnt == 4'd8) begin
                                err_q <= 1'b1;
                                state <= SKIP;
                            end else begin
                                acc <= {acc[27:0], h.nib};
                                cnt <= cnt + 4'd1;
                            end
                        end else if (is_term) begin
                            if (cnt != 4'd0) begin
                                data_q  <= acc;
                                valid_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= SKIP;
                        end
                    end
                    SKIP: if (is_term) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_dword_hex.sv
// Directed bench: drives ASCII frames over a 4-clock-per-bit UART model and checks parsed words and strobes.
module tb_uart_rx_dword_hex;
    localparam int BITCLK = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic rx    = 1'b1;

    int tests  = 0;
    int failed = 0;

    int          v_cnt = 0;
    int          e_cnt = 0;
    int          overlap = 0;
    int          wide = 0;
    logic        prev_v = 1'b0;
    logic        prev_e = 1'b0;
    logic [31:0] last_data = '0;

    uart_rx_dword_hex_if bus();

    uart_rx_dword_hex #(.U_DIV(1)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_uart_rx (rx),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (bus.valid && bus.err) overlap++;
        if ((bus.valid && prev_v) || (bus.err && prev_e)) wide++;
        prev_v = bus.valid;
        prev_e = bus.err;
        if (bus.valid) begin
            v_cnt++;
            last_data = bus.data;
        end
        if (bus.err) e_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (BITCLK) @(negedge i_clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        repeat (20) @(negedge i_clk);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        tests += 4;
        if (bus.data !== 32'h0) begin failed++; $display("FAIL reset_data got %h want 0", bus.data); end
        if (bus.valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        if (bus.err !== 1'b0)   begin failed++; $display("FAIL reset_err got %b want 0", bus.err); end
        if (bus.busy !== 1'b0)  begin failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_full_word;
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        send_str("0x1A2b3C4d\r");
        tests += 3;
        if (v_cnt - v0 !== 1) begin failed++; $display("FAIL full_valid_count got %0d want 1", v_cnt - v0); end
        if (last_data !== 32'h1A2B3C4D) begin failed++; $display("FAIL full_data got %h want 1a2b3c4d", last_data); end
        if (e_cnt - e0 !== 0) begin failed++; $display("FAIL full_err_count got %0d want 0", e_cnt - e0); end
    endtask

    task automatic test_short_words;
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        send_str("0xFF\n");
        tests += 2;
        if (v_cnt - v0 !== 1) begin failed++; $display("FAIL ff_valid_count got %0d want 1", v_cnt - v0); end
        if (last_data !== 32'h000000FF) begin failed++; $display("FAIL ff_data got %h want 000000ff", last_data); end
        v0 = v_cnt;
        send_str("0x0\r\n");
        tests += 3;
        if (v_cnt - v0 !== 1) begin failed++; $display("FAIL zero_valid_count got %0d want 1", v_cnt - v0); end
        if (last_data !== 32'h0) begin failed++; $display("FAIL zero_data got %h want 00000000", last_data); end
        if (e_cnt - e0 !== 0) begin failed++; $display("FAIL short_err_count got %0d want 0", e_cnt - e0); end
    endtask

    task automatic test_overflow;
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        send_str("0x123456789\r0x5\r");
        tests += 3;
        if (e_cnt - e0 !== 1) begin failed++; $display("FAIL ovf_err_count got %0d want 1", e_cnt - e0); end
        if (v_cnt - v0 !== 1) begin failed++; $display("FAIL ovf_valid_count got %0d want 1", v_cnt - v0); end
        if (last_data !== 32'h5) begin failed++; $display("FAIL ovf_data got %h want 00000005", last_data); end
    endtask

    task automatic test_malformed;
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        send_str("0xG1\r");
        tests += 3;
        if (e_cnt - e0 !== 1) begin failed++; $display("FAIL badhex_err_count got %0d want 1", e_cnt - e0); end
        if (bus.data !== 32'h5) begin failed++; $display("FAIL badhex_data got %h want 00000005", bus.data); end
        if (bus.busy !== 1'b0) begin failed++; $display("FAIL badhex_busy got %b want 0", bus.busy); end
        e0 = e_cnt;
        send_str("0x\r");
        tests += 4;
        if (e_cnt - e0 !== 1) begin failed++; $display("FAIL empty_err_count got %0d want 1", e_cnt - e0); end
        if (bus.data !== 32'h5) begin failed++; $display("FAIL empty_data got %h want 00000005", bus.data); end
        if (bus.busy !== 1'b0) begin failed++; $display("FAIL empty_busy got %b want 0", bus.busy); end
        if (v_cnt - v0 !== 0) begin failed++; $display("FAIL malformed_valid_count got %0d want 0", v_cnt - v0); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0;
        v0 = v_cnt; e0 = e_cnt;
        send_str("0x12");
        tests += 1;
        if (bus.busy !== 1'b1) begin failed++; $display("FAIL midframe_busy got %b want 1", bus.busy); end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        send_str("34\r");
        tests += 2;
        if (v_cnt - v0 !== 0) begin failed++; $display("FAIL postrst_valid_count got %0d want 0", v_cnt - v0); end
        if (bus.busy !== 1'b0) begin failed++; $display("FAIL postrst_busy got %b want 0", bus.busy); end
        send_str("0xAB\r");
        tests += 3;
        if (v_cnt - v0 !== 1) begin failed++; $display("FAIL rst_valid_count got %0d want 1", v_cnt - v0); end
        if (last_data !== 32'h000000AB) begin failed++; $display("FAIL rst_data got %h want 000000ab", last_data); end
        if (e_cnt - e0 !== 0) begin failed++; $display("FAIL rst_err_count got %0d want 0", e_cnt - e0); end
    endtask

    task automatic test_strobe_checkers;
        tests += 2;
        if (overlap !== 0) begin failed++; $display("FAIL strobe_overlap got %0d want 0", overlap); end
        if (wide !== 0)    begin failed++; $display("FAIL strobe_width got %0d want 0", wide); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_words();
        test_overflow();
        test_malformed();
        test_reset_mid_frame();
        test_strobe_checkers();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
